decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: field extraction, load-use scoreboard and a single-entry output register.
// One cycle from acceptance to out_valid; in_ready drops on hazard, flush, or a held output not being consumed.
module decode_stage #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int LOAD_LATENCY     = 2,
    parameter int STALL_CNT_SIZE   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [31:0]                 instruction,
    output logic                        in_ready,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [REG_ADDRESS_SIZE-1:0] addr_rd,
    output logic [REG_ADDRESS_SIZE-1:0] addr_r1,
    output logic [REG_ADDRESS_SIZE-1:0] addr_r2,
    output logic [ADDRESS_SIZE-1:0]     immediate,
    output logic                        register_write,
    output logic                        is_load,
    output logic                        is_store,
    output logic                        is_branch,
    output logic                        illegal,
    output logic [STALL_CNT_SIZE-1:0]   stall_count
);

    localparam int NREGS  = 1 << REG_ADDRESS_SIZE;
    localparam int BUSY_W = 4;

    if (ADDRESS_SIZE < 16) begin : g_bad_address_size
        $error("decode_stage: ADDRESS_SIZE must be >= 16");
    end
    if (REG_ADDRESS_SIZE != 5) begin : g_bad_reg_address_size
        $error("decode_stage: REG_ADDRESS_SIZE must be 5");
    end
    if (LOAD_LATENCY < 1 || LOAD_LATENCY > 15) begin : g_bad_load_latency
        $error("decode_stage: LOAD_LATENCY must be in 1..15");
    end

    logic [5:0]                  opcode;
    logic [REG_ADDRESS_SIZE-1:0] f_rd, f_r1, f_r2;
    logic [ADDRESS_SIZE-1:0]     f_imm;

    assign opcode = instruction[31:26];
    assign f_rd   = instruction[25:21];
    assign f_r1   = instruction[20:16];
    assign f_r2   = instruction[15:11];
    assign f_imm  = ADDRESS_SIZE'($signed(instruction[15:0]));

    logic d_writes, d_load, d_store, d_branch, d_illegal;
    logic use_r1, use_r2, use_rd;

    always_comb begin
        d_writes  = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_branch  = 1'b0;
        d_illegal = 1'b0;
        use_r1    = 1'b0;
        use_r2    = 1'b0;
        use_rd    = 1'b0;
        if (opcode == 6'h00) begin
            d_writes = 1'b1;
            use_r1   = 1'b1;
            use_r2   = 1'b1;
        end else if (opcode <= 6'h0F) begin
            d_writes = 1'b1;
            use_r1   = 1'b1;
        end else begin
            case (opcode)
                6'h10: begin
                    d_load   = 1'b1;
                    d_writes = 1'b1;
                    use_r1   = 1'b1;
                end
                // Stores read the rd field as their data source.
                6'h11: begin
                    d_store = 1'b1;
                    use_r1  = 1'b1;
                    use_rd  = 1'b1;
                end
                6'h20: begin
                    d_branch = 1'b1;
                    use_r1   = 1'b1;
                    use_r2   = 1'b1;
                end
                default: d_illegal = 1'b1;
            endcase
        end
    end

    logic                        out_valid_q;
    logic [REG_ADDRESS_SIZE-1:0] rd_q, r1_q, r2_q;
    logic [ADDRESS_SIZE-1:0]     imm_q;
    logic                        rw_q, is_load_q, is_store_q, is_branch_q, illegal_q;
    logic [BUSY_W-1:0]           busy_q [NREGS];
    logic [BUSY_W-1:0]           busy_d [NREGS];
    logic [STALL_CNT_SIZE-1:0]   stall_q, stall_d;

    // A held LOAD blocks its readers even in the cycle it fires; the counter takes over after.
    logic busy_r1, busy_r2, busy_rd, hazard, accept, fire;

    assign busy_r1 = (f_r1 != '0) && ((busy_q[f_r1] != '0) ||
                     (out_valid_q && is_load_q && (rd_q == f_r1)));
    assign busy_r2 = (f_r2 != '0) && ((busy_q[f_r2] != '0) ||
                     (out_valid_q && is_load_q && (rd_q == f_r2)));
    assign busy_rd = (f_rd != '0) && ((busy_q[f_rd] != '0) ||
                     (out_valid_q && is_load_q && (rd_q == f_rd)));
    assign hazard  = in_valid && ((use_r1 && busy_r1) || (use_r2 && busy_r2) || (use_rd && busy_rd));

    assign in_ready = reset && !flush && (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_q && out_ready && !flush;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            busy_d[i] = busy_q[i];
            if (fire && is_load_q && (rd_q != '0) && (rd_q == REG_ADDRESS_SIZE'(i)))
                busy_d[i] = BUSY_W'(LOAD_LATENCY);
            else if (busy_q[i] != '0)
                busy_d[i] = busy_q[i] - 1'b1;
        end
        stall_d = stall_q;
        if (hazard && (!out_valid_q || out_ready) && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) busy_q[i] <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) busy_q[i] <= busy_d[i];
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            imm_q       <= '0;
            rw_q        <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            rd_q        <= f_rd;
            r1_q        <= f_r1;
            r2_q        <= f_r2;
            imm_q       <= f_imm;
            rw_q        <= d_writes && (f_rd != '0);
            is_load_q   <= d_load;
            is_store_q  <= d_store;
            is_branch_q <= d_branch;
            illegal_q   <= d_illegal;
        end else if (fire || flush) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign addr_rd        = rd_q;
    assign addr_r1        = r1_q;
    assign addr_r2        = r2_q;
    assign immediate      = imm_q;
    assign register_write = rw_q;
    assign is_load        = is_load_q;
    assign is_store       = is_store_q;
    assign is_branch      = is_branch_q;
    assign illegal        = illegal_q;
    assign stall_count    = stall_q;

endmodule
